// File: rtl/avr_prog_loader.sv
// rtl/avr_prog_loader.sv - UART bootloader that fills program memory and holds the core until loaded
// Optional trailing checksum byte is compiled in with LOADER_CSUM_EN.
module avr_prog_loader #(
   parameter int CLK_DIV = 16,
   parameter int ADDR_W  = 9
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rx,
   output logic              prog_we,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [15:0]       prog_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      SYNC, LEN_H, LEN_L, DATA_LO, DATA_HI,
`ifdef LOADER_CSUM_EN
      CSUM,
`endif
      DONE, ERR
   } ld_state_t;

   rx_state_t        rx_state, rx_state_nxt;
   logic             rx_meta, rx_sync, rx_prev;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       rx_shift, rx_shift_nxt;
   logic             byte_valid, byte_valid_nxt;
   logic             frame_err, frame_err_nxt;

   ld_state_t        state, state_nxt;
   logic [7:0]       len_h, len_h_nxt;
   logic [ADDR_W-1:0] last_addr, last_nxt, addr_nxt;
   logic [15:0]      wdata_nxt, len_word;
   logic             we_nxt, hold_nxt, done_nxt, err_nxt;
`ifdef LOADER_CSUM_EN
   logic [7:0]       csum, csum_nxt;
`endif

   assign len_word = {len_h, rx_shift};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         bit_idx    <= '0;
         rx_shift   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         rx_state   <= rx_state_nxt;
         rx_cnt     <= rx_cnt_nxt;
         bit_idx    <= bit_idx_nxt;
         rx_shift   <= rx_shift_nxt;
         byte_valid <= byte_valid_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

   // rx_shift keeps the last byte stable until the next byte's data bits arrive
   always_comb begin
      rx_state_nxt   = rx_state;
      rx_cnt_nxt     = rx_cnt + 1'b1;
      bit_idx_nxt    = bit_idx;
      rx_shift_nxt   = rx_shift;
      byte_valid_nxt = 1'b0;
      frame_err_nxt  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_nxt = '0;
            if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
         end
         RX_START: if (rx_cnt == HALF_M1) begin
            rx_cnt_nxt   = '0;
            bit_idx_nxt  = '0;
            rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt == FULL_M1) begin
            rx_cnt_nxt   = '0;
            rx_shift_nxt = {rx_sync, rx_shift[7:1]};
            bit_idx_nxt  = bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
         end
         RX_STOP: if (rx_cnt == FULL_M1) begin
            byte_valid_nxt = rx_sync;
            frame_err_nxt  = !rx_sync;
            rx_state_nxt   = RX_IDLE;
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= SYNC;
         len_h      <= '0;
         last_addr  <= '0;
         prog_we    <= 1'b0;
         prog_addr  <= '0;
         prog_wdata <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum       <= '0;
`endif
      end else begin
         state      <= state_nxt;
         len_h      <= len_h_nxt;
         last_addr  <= last_nxt;
         prog_we    <= we_nxt;
         prog_addr  <= addr_nxt;
         prog_wdata <= wdata_nxt;
         cpu_hold   <= hold_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
`ifdef LOADER_CSUM_EN
         csum       <= csum_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      len_h_nxt = len_h;
      last_nxt  = last_addr;
      we_nxt    = 1'b0;
      addr_nxt  = prog_addr;
      wdata_nxt = prog_wdata;
      hold_nxt  = cpu_hold;
      done_nxt  = done;
      err_nxt   = err;
`ifdef LOADER_CSUM_EN
      csum_nxt  = csum;
`endif
      // address advances the cycle after the write pulse, never during it
      if (prog_we && state == DATA_LO) addr_nxt = prog_addr + 1'b1;
      if (frame_err) begin
         if (state != SYNC && state != DONE && state != ERR) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
            hold_nxt  = 1'b1;
            done_nxt  = 1'b0;
         end
      end else if (byte_valid) begin
         case (state)
            SYNC: if (rx_shift == SYNC_BYTE) state_nxt = LEN_H;
            LEN_H: begin
               len_h_nxt = rx_shift;
               state_nxt = LEN_L;
            end
            LEN_L: begin
               if (len_word == 16'd0 || {1'b0, len_word} > MAX_LEN) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  hold_nxt  = 1'b1;
                  done_nxt  = 1'b0;
               end else begin
                  last_nxt  = ADDR_W'(len_word - 16'd1);
                  addr_nxt  = '0;
                  state_nxt = DATA_LO;
`ifdef LOADER_CSUM_EN
                  csum_nxt  = '0;
`endif
               end
            end
            DATA_LO: begin
               wdata_nxt[7:0] = rx_shift;
               state_nxt      = DATA_HI;
`ifdef LOADER_CSUM_EN
               csum_nxt       = csum + rx_shift;
`endif
            end
            DATA_HI: begin
               wdata_nxt[15:8] = rx_shift;
               we_nxt          = 1'b1;
`ifdef LOADER_CSUM_EN
               csum_nxt        = csum + rx_shift;
`endif
               if (prog_addr == last_addr) begin
`ifdef LOADER_CSUM_EN
                  state_nxt = CSUM;
`else
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  hold_nxt  = 1'b0;
                  err_nxt   = 1'b0;
`endif
               end else begin
                  state_nxt = DATA_LO;
               end
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
               if (rx_shift == csum) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  hold_nxt  = 1'b0;
                  err_nxt   = 1'b0;
               end else begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  hold_nxt  = 1'b1;
                  done_nxt  = 1'b0;
               end
            end
`endif
            DONE, ERR: if (rx_shift == SYNC_BYTE) begin
               state_nxt = LEN_H;
               done_nxt  = 1'b0;
               err_nxt   = 1'b0;
               hold_nxt  = 1'b1;
            end
            default: state_nxt = SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_avr_prog_loader.sv
// tb/tb_avr_prog_loader.sv - randomized self-checking bench for avr_prog_loader
// Frame-level reference model; follows LOADER_CSUM_EN the same way as the design.
module tb_avr_prog_loader;
   localparam int CLK_DIV = 16;
   localparam int ADDR_W  = 9;
`ifdef LOADER_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              rx  = 1'b1;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [15:0]       prog_wdata;
   logic              cpu_hold, done, err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0]          tx_q[$];
   bit                  tx_fe[$];
   logic [ADDR_W+15:0]  obs_q[$];
   logic [ADDR_W+15:0]  exp_q[$];
   bit m_done, m_err, m_hold;

   avr_prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST(RST), .rx(rx),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (RST && prog_we) obs_q.push_back({prog_addr, prog_wdata});

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic void add(input logic [7:0] b, input bit fe);
      tx_q.push_back(b);
      tx_fe.push_back(fe);
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLK_DIV) @(negedge CLK);
      end
      rx = !bad_stop;
      repeat (CLK_DIV) @(negedge CLK);
      rx = 1'b1;
      repeat (2 * CLK_DIV) @(negedge CLK);
   endtask

   // Walks the byte stream frame by frame: hunt for 0xA5, then length, words, optional checksum.
   task automatic model_run();
      int p;
      int n;
      p = 0;
      n = tx_q.size();
      while (p < n) begin
         int len;
         logic [7:0] lo;
         logic [7:0] sum;
         bit bad;
         bit csum_ok;
         if (tx_fe[p] || tx_q[p] != 8'hA5) begin
            p++;
            continue;
         end
         p++;
         m_hold = 1; m_done = 0; m_err = 0;
         bad = 0; csum_ok = 1; len = 0; sum = 0;
         for (int j = 0; j < 2 && !bad; j++) begin
            if (p >= n) return;
            if (tx_fe[p]) bad = 1;
            else len = (len << 8) | int'(tx_q[p]);
            p++;
         end
         if (!bad && (len == 0 || len > (1 << ADDR_W))) begin
            m_err = 1;
            continue;
         end
         for (int w = 0; w < len && !bad; w++) begin
            if (p >= n) return;
            if (tx_fe[p]) begin bad = 1; p++; break; end
            lo = tx_q[p];
            p++;
            if (p >= n) return;
            if (tx_fe[p]) begin bad = 1; p++; break; end
            exp_q.push_back({ADDR_W'(w), tx_q[p], lo});
            sum = sum + lo + tx_q[p];
            p++;
         end
         if (!bad && CSUM_EN) begin
            if (p >= n) return;
            if (tx_fe[p]) bad = 1;
            else csum_ok = (tx_q[p] == sum);
            p++;
         end
         if (bad || !csum_ok) m_err = 1;
         else begin m_done = 1; m_hold = 0; end
      end
   endtask

   task automatic run_seq(input string tag);
      logic [ADDR_W+15:0] o, e;
      foreach (tx_q[i]) send_byte(tx_q[i], tx_fe[i]);
      repeat (4 * CLK_DIV) @(negedge CLK);
      model_run();
      check({tag, "_nwr"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_wr"}, o, e);
      end
      check({tag, "_done"}, done, m_done);
      check({tag, "_err"}, err, m_err);
      check({tag, "_hold"}, cpu_hold, m_hold);
      check({tag, "_we_idle"}, prog_we, 0);
      obs_q.delete(); exp_q.delete(); tx_q.delete(); tx_fe.delete();
   endtask

   task automatic add_valid();
      add(8'hA5, 0); add(8'h00, 0); add(8'h02, 0);
      add(8'h0C, 0); add(8'h94, 0); add(8'h34, 0); add(8'h12, 0); add(8'hE6, 0);
   endtask

   task automatic rand_frame();
      int kind, len, ng, start, fe_at, lv;
      logic [7:0] b, sum;
      kind = int'($urandom_range(0, 4));
      len  = int'($urandom_range(1, 5));
      ng   = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
         do b = 8'($urandom); while (b == 8'hA5);
         add(b, $urandom_range(0, 3) == 0);
      end
      add(8'hA5, 0);
      start = tx_q.size();
      if (kind == 2) begin
         add(8'h00, 0); add(8'h00, 0);
      end else if (kind == 3) begin
         lv = int'($urandom_range(513, 65535));
         add(8'(lv >> 8), 0); add(8'(lv), 0);
      end else begin
         add(8'(len >> 8), 0); add(8'(len), 0);
         sum = 0;
         for (int i = 0; i < 2 * len; i++) begin
            b = 8'($urandom);
            add(b, 0);
            sum = sum + b;
         end
         if (CSUM_EN) add((kind == 1) ? 8'(sum + 8'($urandom_range(1, 255))) : sum, 0);
         if (kind == 4) begin
            fe_at = int'($urandom_range(start, tx_q.size() - 1));
            tx_fe[fe_at] = 1;
            while (tx_q.size() > fe_at + 1) begin
               void'(tx_q.pop_back());
               void'(tx_fe.pop_back());
            end
         end
      end
   endtask

   initial begin
      bit seen;
      repeat (5) @(negedge CLK);
      check("rst_we", prog_we, 0);
      check("rst_addr", prog_addr, 0);
      check("rst_wdata", prog_wdata, 0);
      check("rst_hold", cpu_hold, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      RST = 1'b1;
      m_hold = 1; m_done = 0; m_err = 0;
      repeat (5) @(negedge CLK);

      add_valid();
      run_seq("valid");
      add(8'hA5, 0); add(8'h00, 0); add(8'h02, 0);
      add(8'h0C, 0); add(8'h94, 0); add(8'h34, 0); add(8'h12, 0); add(8'h00, 0);
      run_seq("badcsum");
      add(8'h55, 0); add(8'h13, 0);
      add_valid();
      run_seq("garbage");
      add(8'hA5, 0); add(8'h00, 0); add(8'h00, 0);
      run_seq("len0");
      add(8'hA5, 0); add(8'h02, 0); add(8'h01, 0);
      run_seq("len513");
      add(8'hA5, 0); add(8'h00, 0); add(8'h02, 0);
      add(8'h0C, 0); add(8'h94, 0); add(8'h34, 0); add(8'h12, 1);
      run_seq("ferr");
      add_valid();
      run_seq("recover");

      // abort a load after its first word has been written
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'h0C, 0); send_byte(8'h94, 0);
      seen = 0;
      for (int c = 0; c < 8 * CLK_DIV && !seen; c++) begin
         if (obs_q.size() > 0) seen = 1;
         else @(negedge CLK);
      end
      check("mid_first_we_seen", seen, 1);
      check("mid_nwr", obs_q.size(), 1);
      if (obs_q.size() > 0) check("mid_wr", obs_q[0], {ADDR_W'(0), 16'h940C});
      RST = 1'b0;
      #1;
      check("abort_we", prog_we, 0);
      check("abort_addr", prog_addr, 0);
      check("abort_wdata", prog_wdata, 0);
      check("abort_hold", cpu_hold, 1);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      repeat (10) @(negedge CLK);
      obs_q.delete();
      RST = 1'b1;
      m_hold = 1; m_done = 0; m_err = 0;
      repeat (5) @(negedge CLK);
      add_valid();
      run_seq("after_rst");

      for (int f = 0; f < 10; f++) begin
         rand_frame();
         run_seq("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
